// File: rtl/wb_stage.sv
// Writeback stage: buffers memory-stage results in a small FIFO and drains them
// into the register file (GPR write port) and the HI/LO pair, counting retirements.
module wb_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_ready,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] retire_cnt,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
    } wb_entry_t;

    wb_entry_t     mem [DEPTH];
    wb_entry_t     head;
    wb_entry_t     entry_in;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          commit;

    assign entry_in = '{wd: wd_i, wreg: wreg_i, wdata: wdata_i,
                        hi: hi_i, lo: lo_i, whilo: whilo_i};
    assign head     = mem[rd_ptr];

    assign busy     = (count != '0);
    assign in_ready = (count < CNT_FULL) && !flush;
    assign push     = in_valid && in_ready;

    // GPR 0 is hardwired, so such entries retire without claiming the write port.
    assign rf_we    = busy && head.wreg && (head.wd != 5'd0);
    assign rf_waddr = busy ? head.wd    : 5'd0;
    assign rf_wdata = busy ? head.wdata : 32'd0;
    assign commit   = busy && (rf_ready || !rf_we) && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hi_o       <= 32'd0;
            lo_o       <= 32'd0;
            retire_cnt <= 32'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                retire_cnt <= retire_cnt + 32'd1;
                if (head.whilo) begin
                    hi_o <= head.hi;
                    lo_o <= head.lo;
                end
            end
            // Simultaneous push and commit leaves occupancy unchanged.
            case ({push, commit})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
